// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester byte arbiter in front of an SPI byte engine.
// Define SPI_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module spi_arbiter (
  input  logic       FastClk,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic [7:0] TxData0,
  input  logic [7:0] TxData1,
  input  logic [1:0] Last,
  output logic [1:0] Ack,
  output logic [7:0] RxData,
  output logic       Owner,
  output logic       Locked,
  output logic       SpiStart,
  output logic [7:0] SpiDataOut,
  output logic       SpiKeepCS,
  input  logic       SpiBusy,
  input  logic [7:0] SpiDataIn
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    LOCKED
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       locked_q, locked_d;
  logic       start_q, start_d;
  logic       keep_q, keep_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] rx_q, rx_d;
  logic [1:0] ack_q, ack_d;
  logic       grant;

  // Winner of an IDLE arbitration round
`ifdef SPI_ARB_FIXED_PRIO_EN
  assign grant = ~Req[0];
`else
  assign grant = (&Req) ? ~owner_q : ~Req[0];
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    start_d  = 1'b0;
    keep_d   = keep_q;
    dout_d   = dout_q;
    rx_d     = rx_q;
    ack_d    = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (!SpiBusy && (|Req)) begin
          owner_d = grant;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        dout_d  = owner_q ? TxData1 : TxData0;
        keep_d  = ~Last[owner_q];
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (SpiBusy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!SpiBusy) begin
          rx_d     = SpiDataIn;
          ack_d    = owner_q ? 2'b10 : 2'b01;
          // Held CS of the finished byte decides whether the burst goes on
          locked_d = keep_q;
          state_d  = keep_q ? LOCKED : IDLE;
        end
      end
      LOCKED: begin
        if (Req[owner_q] && !SpiBusy) state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge FastClk) begin
    if (Reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b1;
      locked_q <= 1'b0;
      start_q  <= 1'b0;
      keep_q   <= 1'b0;
      dout_q   <= 8'h00;
      rx_q     <= 8'h00;
      ack_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      start_q  <= start_d;
      keep_q   <= keep_d;
      dout_q   <= dout_d;
      rx_q     <= rx_d;
      ack_q    <= ack_d;
    end
  end

  assign Ack        = ack_q;
  assign RxData     = rx_q;
  assign Owner      = owner_q;
  assign Locked     = locked_q;
  assign SpiStart   = start_q;
  assign SpiDataOut = dout_q;
  assign SpiKeepCS  = keep_q;

endmodule
